// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and
// default timing constants (also used by the receive path).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP
    } ps2_state_e;

    localparam int PS2_FRAME_W        = 9;
    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_TIMER_W        = 20;
    localparam int PS2_RTS_CYCLES     = 5000;    // 100 us at 50 MHz
    localparam int PS2_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz
    localparam int PS2_FILTER_LEN     = 8;

    // Data byte with odd parity on top, shifted out LSB first.
    function automatic logic [PS2_FRAME_W-1:0] ps2_frame(input logic [7:0] b);
        return {~^b, b};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock line: the level only changes after
// FILTER_LEN identical samples; fall_edge marks a filtered 1->0 change.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2c_in,
    output logic ps2c_f,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] sr_q, sr_d;
    logic                  f_q, f_d;

    always_comb begin
        sr_d = {ps2c_in, sr_q[FILTER_LEN-1:1]};
        f_d  = f_q;
        if (&sr_d)
            f_d = 1'b1;
        else if (~|sr_d)
            f_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '1;
            f_q  <= 1'b1;
        end else begin
            sr_q <= sr_d;
            f_q  <= f_d;
        end
    end

    assign ps2c_f    = f_q;
    assign fall_edge = f_q & ~f_d;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter (open-drain ps2c/ps2d, drives only 0).
// Optional macro PS2_TX_ACK_CHECK_EN adds the ack_err output.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  logic       ps2c,
    inout  logic       ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_timeout_tick
`ifdef PS2_TX_ACK_CHECK_EN
    ,
    output logic       ack_err
`endif
);

    localparam logic [PS2_TIMER_W-1:0] RTS_LOAD = PS2_TIMER_W'(RTS_CYCLES - 1);
    localparam logic [PS2_TIMER_W-1:0] TMO_LOAD = PS2_TIMER_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e                state_q, state_d;
    logic [PS2_FRAME_W-1:0]    frame_q, frame_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [PS2_TIMER_W-1:0]    timer_q, timer_d;
    logic                      c_tri_q, c_tri_d;
    logic                      d_tri_q, d_tri_d;
    logic                      idle_q, idle_d;
    logic                      done_q, done_d;
    logic                      tmo_q, tmo_d;
    logic                      ack_q, ack_d;
    logic                      fall_edge;
    logic                      unused_lvl;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2c_in   (ps2c),
        .ps2c_f    (unused_lvl),
        .fall_edge (fall_edge)
    );

    // Enables and ticks are computed for the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        c_tri_d = 1'b0;
        d_tri_d = 1'b0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    frame_d = ps2_frame(din);
                    timer_d = RTS_LOAD;
                    c_tri_d = 1'b1;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                c_tri_d = 1'b1;
                if (timer_q == '0) begin
                    timer_d = TMO_LOAD;
                    c_tri_d = 1'b0;
                    d_tri_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_START: begin
                d_tri_d = 1'b1;
                if (fall_edge) begin
                    cnt_d   = 4'(PS2_DATA_BITS);
                    timer_d = TMO_LOAD;
                    d_tri_d = ~frame_q[0];
                    state_d = ST_DATA;
                end else if (timer_q == '0) begin
                    d_tri_d = 1'b0;
                    tmo_d   = 1'b1;
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                d_tri_d = ~frame_q[0];
                if (fall_edge) begin
                    timer_d = TMO_LOAD;
                    if (cnt_q == '0) begin
                        d_tri_d = 1'b0;
                        state_d = ST_STOP;
                    end else begin
                        frame_d = frame_q >> 1;
                        cnt_d   = cnt_q - 1'b1;
                        d_tri_d = ~frame_q[1];
                    end
                end else if (timer_q == '0) begin
                    d_tri_d = 1'b0;
                    tmo_d   = 1'b1;
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    done_d  = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
                    // Device pulls data low with its last clock to acknowledge.
                    ack_d   = ps2d;
`endif
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    tmo_d   = 1'b1;
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            c_tri_q <= 1'b0;
            d_tri_q <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            c_tri_q <= c_tri_d;
            d_tri_q <= d_tri_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
        end
    end

    assign ps2c            = c_tri_q ? 1'b0 : 1'bz;
    assign ps2d            = d_tri_q ? 1'b0 : 1'bz;
    assign tx_idle         = idle_q;
    assign tx_done_tick    = done_q;
    assign tx_timeout_tick = tmo_q;
`ifdef PS2_TX_ACK_CHECK_EN
    assign ack_err         = ack_q;
`else
    logic unused_ack;
    assign unused_ack = ack_q;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device with pull-ups, scoreboard of sent
// bytes checked against what the device samples off the wire.
module tb_ps2_tx;

    localparam int RTS  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_idle, tx_done_tick, tx_timeout_tick;
`ifdef PS2_TX_ACK_CHECK_EN
    logic       ack_err;
`endif
    wire        ps2c, ps2d;
    logic       dev_c = 1'b0;   // 1 = device pulls clock low
    logic       dev_d = 1'b0;   // 1 = device pulls data low

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    logic [7:0] sb_q[$];

    ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_ps2          (wr_ps2),
        .din             (din),
        .ps2c            (ps2c),
        .ps2d            (ps2d),
        .tx_idle         (tx_idle),
        .tx_done_tick    (tx_done_tick),
        .tx_timeout_tick (tx_timeout_tick)
`ifdef PS2_TX_ACK_CHECK_EN
        ,
        .ack_err         (ack_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_timeout_tick) tmo_cnt <= tmo_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse wr_ps2 and check the request-to-send low time on the wire.
    task automatic send(input logic [7:0] b, input bit push);
        int w, t0, t1;
        @(negedge clk);
        wr_ps2 = 1'b1;
        din    = b;
        if (push) sb_q.push_back(b);
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'h00;
        w = 0;
        while (ps2c !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        t0 = cyc;
        w = 0;
        while (ps2c !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        t1 = cyc;
        check("rts_len", t1 - t0, RTS);
    endtask

    // Device: waits for RTS, samples start bit, then generates n_edges clocks.
    task automatic dev_frame(input int n_edges, input bit ack, input int glitch_at);
        int w;
        logic [10:0] bits;
        logic [7:0]  exp;
        bits = '0;
        w = 0;
        while (ps2c !== 1'b0 && w < 1000) begin @(negedge clk); w++; end
        w = 0;
        while (ps2c !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        bits[0] = ps2d;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == glitch_at) begin
                repeat (20) @(negedge clk);
                dev_c = 1'b1;
                repeat (2) @(negedge clk);
                dev_c = 1'b0;
                repeat (HALF - 22) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k == 11 && ack) dev_d = 1'b1;
            dev_c = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c = 1'b0;
            if (k <= 10) bits[k] = ps2d;
        end
        repeat (HALF) @(negedge clk);
        dev_d = 1'b0;
        if (n_edges == 11) begin
            check("sb_avail", sb_q.size() > 0, 1);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
            check("start_bit", bits[0], 1'b0);
            check("data", bits[8:1], exp);
            check("parity", bits[9], ~^exp);
            check("stop_bit", bits[10], 1'b1);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input int glitch_at, input bit inject);
        int d0;
        d0 = done_cnt;
        fork
            dev_frame(11, ack, glitch_at);
            begin
                send(b, 1'b1);
                if (inject) begin
                    repeat (300) @(negedge clk);
                    wr_ps2 = 1'b1;
                    din    = 8'h55;
                    @(negedge clk);
                    wr_ps2 = 1'b0;
                    din    = 8'h00;
                end
            end
        join
        repeat (20) @(negedge clk);
        check("done_cnt", done_cnt - d0, 1);
        check("idle_after", tx_idle, 1'b1);
    endtask

    task automatic run_timeout();
        int d0, k0, w, ts;
        d0 = done_cnt;
        k0 = tmo_cnt;
        send(8'hAA, 1'b0);
        ts = cyc;
        w = 0;
        while (tx_timeout_tick !== 1'b1 && w < 400) begin @(negedge clk); w++; end
        check("tmo_latency", cyc - ts, TMO);
        check("tmo_ps2c", ps2c, 1'b1);
        check("tmo_ps2d", ps2d, 1'b1);
        check("tmo_idle", tx_idle, 1'b1);
        repeat (10) @(negedge clk);
        check("tmo_count", tmo_cnt - k0, 1);
        check("tmo_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_idle", tx_idle, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_tmo", tx_timeout_tick, 1'b0);
        check("rst_ps2c", ps2c, 1'b1);
        check("rst_ps2d", ps2d, 1'b1);
`ifdef PS2_TX_ACK_CHECK_EN
        check("rst_ack_err", ack_err, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        run_frame(8'hED, 1'b1, 0, 1'b0);
        run_frame(8'h00, 1'b1, 0, 1'b0);
        run_frame(8'hFF, 1'b1, 0, 1'b0);
        run_frame(8'hF4, 1'b1, 0, 1'b1);
        run_frame(8'hA5, 1'b1, 4, 1'b0);

`ifdef PS2_TX_ACK_CHECK_EN
        run_frame(8'h12, 1'b0, 0, 1'b0);
        check("ack_err_nack", ack_err, 1'b1);
        run_frame(8'h34, 1'b1, 0, 1'b0);
        check("ack_err_ack", ack_err, 1'b0);
        run_frame(8'h56, 1'b0, 0, 1'b0);
        check("ack_err_nack2", ack_err, 1'b1);
`endif
        run_timeout();
`ifdef PS2_TX_ACK_CHECK_EN
        check("ack_err_tmo", ack_err, 1'b0);
`endif

        // Reset in DATA while ps2d is driven low (0xC3 presents bit 2 = 0 after edge 3).
        fork
            send(8'hC3, 1'b0);
            dev_frame(3, 1'b1, 0);
        join
        repeat (5) @(negedge clk);
        check("pre_rst_ps2d", ps2d, 1'b0);
        check("pre_rst_idle", tx_idle, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ps2c", ps2c, 1'b1);
        check("rst_mid_ps2d", ps2d, 1'b1);
        check("rst_mid_idle", tx_idle, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_frame(8'h5A, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
